// File: rtl/alu_cmd_arbiter.sv
// alu_cmd_arbiter: round-robin front end that shares one ALU between two
// requesters. Only one operation is in flight; the ALU gets a one-cycle
// enable pulse. If the ALU has not answered after TIMEOUT wait cycles, the
// operation completes with an error response.
module alu_cmd_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             hclk_i,
    input  logic             hresetn_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [3:0]       req_opcode_i,
    input  logic [31:0]      req_opa_i,
    input  logic [31:0]      req_opb_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             enable_o,
    output logic [1:0]       opcode_o,
    output logic [15:0]      operate_a_o,
    output logic [15:0]      operate_b_o,
    input  logic             alu_done_i,
    input  logic [WIDTH-1:0] alu_res_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Last wait-count value before the operation is declared timed out.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic [7:0]        count_reg, count_next;
    logic              gnt_id_reg, gnt_id_next;
    logic [1:0]        opcode_reg, opcode_next;
    logic [15:0]       opa_reg, opa_next;
    logic [15:0]       opb_reg, opb_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic              err_reg, err_next;

    logic              grant_valid;
    logic              grant_id;

    // Per-requester views of the packed command buses.
    logic [1:0]        req_op [2];
    logic [15:0]       req_a  [2];
    logic [15:0]       req_b  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_op[gi] = req_opcode_i[2*gi +: 2];
            assign req_a[gi]  = req_opa_i[16*gi +: 16];
            assign req_b[gi]  = req_opb_i[16*gi +: 16];
        end
    endgenerate

    // Round-robin choice: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ptr_reg;
        case (req_valid_i)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ptr_reg;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = ptr_reg;
            end
        endcase
    end

    // Accept only on the granted bit, only while idle and out of reset.
    always_comb begin
        req_ready_o = 2'b00;
        if (hresetn_i && (state_reg == ST_IDLE) && grant_valid) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        count_next  = count_reg;
        gnt_id_next = gnt_id_reg;
        opcode_next = opcode_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        data_next   = data_reg;
        err_next    = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next  = ST_ISSUE;
                    gnt_id_next = grant_id;
                    opcode_next = req_op[grant_id];
                    opa_next    = req_a[grant_id];
                    opb_next    = req_b[grant_id];
                end
            end
            ST_ISSUE: begin
                count_next = 8'd0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still beats the timeout.
                if (alu_done_i) begin
                    data_next  = alu_res_i;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (count_reg == COUNT_LAST) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                    ptr_next   = ~gnt_id_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; active-low reset abandons any operation.
    always_ff @(posedge hclk_i) begin
        if (!hresetn_i) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 1'b0;
            count_reg  <= 8'd0;
            gnt_id_reg <= 1'b0;
            opcode_reg <= 2'd0;
            opa_reg    <= 16'd0;
            opb_reg    <= 16'd0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            count_reg  <= count_next;
            gnt_id_reg <= gnt_id_next;
            opcode_reg <= opcode_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
        end
    end

    assign enable_o    = (state_reg == ST_ISSUE);
    assign rsp_valid_o = (state_reg == ST_RESP);
    assign rsp_id_o    = gnt_id_reg;
    assign rsp_data_o  = data_reg;
    assign rsp_err_o   = err_reg;
    assign opcode_o    = opcode_reg;
    assign operate_a_o = opa_reg;
    assign operate_b_o = opb_reg;

endmodule
